// File: rtl/stream_demux.sv
// Packetised valid/ready demultiplexer: one input stream fanned out to P_NUM_OUTPUTS outputs,
// destination latched per packet. Optional STREAM_DEMUX_DROP_INVALID_EN discards out-of-range packets.
module stream_demux #(
    parameter int P_DATA_WIDTH  = 32,
    parameter int P_NUM_OUTPUTS = 3,
    localparam int P_DEST_WIDTH = $clog2(P_NUM_OUTPUTS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_in,
    input  logic                     last_in,
    input  logic [P_DATA_WIDTH-1:0]  data_in,
    input  logic [P_DEST_WIDTH-1:0]  dest_in,
    output logic                     ready_in,
    output logic [P_NUM_OUTPUTS-1:0] valid_out,
    output logic [P_NUM_OUTPUTS-1:0] last_out,
    output logic [P_DATA_WIDTH-1:0]  data_out [P_NUM_OUTPUTS],
    input  logic [P_NUM_OUTPUTS-1:0] ready_out,
    output logic                     dropped_out
);

    localparam logic [P_DEST_WIDTH:0] NUM_OUT = (P_DEST_WIDTH + 1)'(P_NUM_OUTPUTS);

    logic                    in_pkt;
    logic [P_DEST_WIDTH-1:0] pkt_dest;
    logic                    out_vld;
    logic [P_DEST_WIDTH-1:0] out_dest;
    logic                    out_last;
    logic [P_DATA_WIDTH-1:0] out_data;

    logic                    sel_ready;
    logic                    dest_oor;
    logic                    beat_drop;
    logic                    accept;
    logic                    load;
    logic [P_DEST_WIDTH-1:0] first_dest;
    logic [P_DEST_WIDTH-1:0] beat_dest;

    always_comb begin
        sel_ready = 1'b0;
        for (int i = 0; i < P_NUM_OUTPUTS; i++) begin
            if (out_dest == P_DEST_WIDTH'(i)) begin
                sel_ready = ready_out[i];
            end
        end
    end

    // Out-of-range destinations fold to output 0 unless the packet is being dropped.
    assign dest_oor   = {1'b0, dest_in} >= NUM_OUT;
    assign first_dest = dest_oor ? '0 : dest_in;
    assign beat_dest  = in_pkt ? pkt_dest : first_dest;

`ifdef STREAM_DEMUX_DROP_INVALID_EN
    logic pkt_drop;
    logic drop_pulse;

    assign beat_drop = in_pkt ? pkt_drop : dest_oor;

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_drop   <= 1'b0;
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= accept && beat_drop && last_in;
            if (accept && !in_pkt) begin
                pkt_drop <= dest_oor;
            end
        end
    end

    assign dropped_out = drop_pulse;
`else
    assign beat_drop   = 1'b0;
    assign dropped_out = 1'b0;
`endif

    assign ready_in = beat_drop || !out_vld || sel_ready;
    assign accept   = valid_in && ready_in;
    assign load     = accept && !beat_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            in_pkt   <= 1'b0;
            pkt_dest <= '0;
            out_vld  <= 1'b0;
            out_dest <= '0;
            out_last <= 1'b0;
            out_data <= '0;
        end else begin
            if (load) begin
                out_vld  <= 1'b1;
                out_dest <= beat_dest;
                out_last <= last_in;
                out_data <= data_in;
            end else if (out_vld && sel_ready) begin
                out_vld <= 1'b0;
            end
            if (accept) begin
                if (!in_pkt) begin
                    pkt_dest <= first_dest;
                end
                in_pkt <= !last_in;
            end
        end
    end

    for (genvar g = 0; g < P_NUM_OUTPUTS; g++) begin : g_out
        assign valid_out[g] = out_vld && (out_dest == P_DEST_WIDTH'(g));
        assign last_out[g]  = out_last;
        assign data_out[g]  = out_data;
    end

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: vector table plus scoreboard of accepted beats,
// with hand-written reset sequences. Follows STREAM_DEMUX_DROP_INVALID_EN if defined.
module tb_stream_demux;

`ifdef STREAM_DEMUX_DROP_INVALID_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic        last_in;
    logic [31:0] data_in;
    logic [1:0]  dest_in;
    logic        ready_in;
    logic [2:0]  valid_out;
    logic [2:0]  last_out;
    logic [31:0] data_out [3];
    logic [2:0]  ready_out;
    logic        dropped_out;

    stream_demux #(.P_DATA_WIDTH(32), .P_NUM_OUTPUTS(3)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .last_in(last_in), .data_in(data_in),
        .dest_in(dest_in), .ready_in(ready_in), .valid_out(valid_out), .last_out(last_out),
        .data_out(data_out), .ready_out(ready_out), .dropped_out(dropped_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  dest;
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic        v;
        logic        l;
        logic [1:0]  d;
        logic [31:0] data;
        logic [2:0]  ro;
        logic        exp_rdy;
        logic [2:0]  exp_vout;
    } vec_t;

    beat_t sb[$];
    vec_t  tbl[$];
    int    total = 0;
    int    bad   = 0;

    logic       m_in_pkt   = 1'b0;
    logic [1:0] m_pkt_dest = 2'd0;
    logic       m_pkt_drop = 1'b0;
    logic       exp_drop   = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle at the negedge, check settled outputs, update the model, advance.
    task automatic step(input logic v, input logic l, input logic [1:0] d, input logic [31:0] dt,
                        input logic [2:0] ro, input logic chk_zero,
                        input logic chk_tbl, input logic t_rdy, input logic [2:0] t_vout);
        logic       oor;
        logic       bdrop;
        logic [1:0] bdest;
        logic       exp_rdy;
        beat_t      f;
        valid_in  = v;
        last_in   = l;
        dest_in   = d;
        data_in   = dt;
        ready_out = ro;
        #2;
        if (rst) begin
            if (chk_zero) begin
                check("rst_valid_out", 64'(valid_out), 64'(0));
                check("rst_dropped_out", 64'(dropped_out), 64'(0));
            end
            sb.delete();
            m_in_pkt   = 1'b0;
            m_pkt_dest = 2'd0;
            m_pkt_drop = 1'b0;
            exp_drop   = 1'b0;
        end else begin
            oor     = (d == 2'd3);
            bdrop   = DROP_EN && (m_in_pkt ? m_pkt_drop : oor);
            bdest   = m_in_pkt ? m_pkt_dest : (oor ? 2'd0 : d);
            exp_rdy = bdrop || (sb.size() == 0) || ro[sb[0].dest];
            if (chk_tbl) begin
                check("tbl_ready_in", 64'(ready_in), 64'(t_rdy));
                check("tbl_valid_out", 64'(valid_out), 64'(t_vout));
            end
            check("ready_in", 64'(ready_in), 64'(exp_rdy));
            check("dropped_out", 64'(dropped_out), 64'(exp_drop));
            exp_drop = 1'b0;
            if (sb.size() == 0) begin
                check("idle_valid_out", 64'(valid_out), 64'(0));
            end else begin
                f = sb[0];
                check("beat_valid_out", 64'(valid_out), 64'(3'b001 << f.dest));
                check("beat_data", 64'(data_out[f.dest]), 64'(f.data));
                check("beat_last", 64'(last_out[f.dest]), 64'(f.last));
                if (ro[f.dest]) void'(sb.pop_front());
            end
            if (v && exp_rdy) begin
                if (!bdrop) sb.push_back('{dest: bdest, data: dt, last: l});
                else if (l) exp_drop = 1'b1;
                if (!m_in_pkt) begin
                    m_pkt_dest = oor ? 2'd0 : d;
                    m_pkt_drop = DROP_EN && oor;
                end
                m_in_pkt = !l;
            end
        end
        @(negedge clk);
    endtask

    task automatic add(input logic v, input logic l, input logic [1:0] d, input logic [31:0] dt,
                       input logic [2:0] ro, input logic rdy, input logic [2:0] vout);
        tbl.push_back('{v: v, l: l, d: d, data: dt, ro: ro, exp_rdy: rdy, exp_vout: vout});
    endtask

    task automatic go(input logic v, input logic l, input logic [1:0] d, input logic [31:0] dt,
                      input logic [2:0] ro);
        step(v, l, d, dt, ro, 1'b0, 1'b0, 1'b0, 3'b000);
    endtask

    initial begin
        rst       = 1'b1;
        valid_in  = 1'b1;
        last_in   = 1'b0;
        dest_in   = 2'd0;
        data_in   = 32'h0;
        ready_out = 3'b111;

        // 3-beat packet to output 2, then back-to-back 1 -> 0 with dest_in toggled mid-packet
        add(1, 0, 2, 32'hA0, 3'b111, 1, 3'b000);
        add(1, 0, 2, 32'hA1, 3'b111, 1, 3'b100);
        add(1, 1, 2, 32'hA2, 3'b111, 1, 3'b100);
        add(1, 0, 1, 32'hB0, 3'b111, 1, 3'b100);
        add(1, 1, 2, 32'hB1, 3'b111, 1, 3'b010);
        add(1, 1, 0, 32'hC0, 3'b111, 1, 3'b010);
        add(0, 0, 0, 32'h0,  3'b111, 1, 3'b001);
        add(0, 0, 0, 32'h0,  3'b111, 1, 3'b000);
        // output 0 stalled 4 cycles while output 1 is ready
        add(1, 0, 0, 32'hD0, 3'b111, 1, 3'b000);
        add(1, 0, 0, 32'hD1, 3'b110, 0, 3'b001);
        add(1, 0, 0, 32'hD1, 3'b110, 0, 3'b001);
        add(1, 0, 0, 32'hD1, 3'b110, 0, 3'b001);
        add(1, 0, 0, 32'hD1, 3'b110, 0, 3'b001);
        add(1, 0, 0, 32'hD1, 3'b111, 1, 3'b001);
        add(1, 1, 0, 32'hD2, 3'b111, 1, 3'b001);
        add(0, 0, 0, 32'h0,  3'b111, 1, 3'b001);
        add(0, 0, 0, 32'h0,  3'b111, 1, 3'b000);
        // out-of-range destination: output 0 by default, dropped with the macro
        add(1, 0, 3, 32'hE0, 3'b111, 1, 3'b000);
        add(1, 1, 3, 32'hE1, 3'b111, 1, DROP_EN ? 3'b000 : 3'b001);
        add(0, 0, 0, 32'h0,  3'b111, 1, DROP_EN ? 3'b000 : 3'b001);
        add(0, 0, 0, 32'h0,  3'b111, 1, 3'b000);

        @(negedge clk);
        for (int i = 0; i < 3; i++) step(1, 0, 2'd1, 32'h55, 3'b111, 1'b1, 1'b0, 1'b0, 3'b000);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].data, tbl[i].ro, 1'b0,
                 1'b1, tbl[i].exp_rdy, tbl[i].exp_vout);
        end

        // reset after beat 2 of a 4-beat packet to output 0
        go(1, 0, 2'd0, 32'hF0, 3'b111);
        go(1, 0, 2'd0, 32'hF1, 3'b111);
        rst = 1'b1;
        go(1, 0, 2'd0, 32'hF2, 3'b111);
        rst = 1'b0;
        go(0, 0, 2'd0, 32'h0, 3'b111);
        go(0, 0, 2'd0, 32'h0, 3'b111);
        go(1, 0, 2'd1, 32'h60, 3'b111);
        go(1, 1, 2'd0, 32'h61, 3'b111);
        go(0, 0, 2'd0, 32'h0, 3'b111);
        go(0, 0, 2'd0, 32'h0, 3'b111);

        // single-beat packets with gaps and a stall on the selected output only
        go(1, 1, 2'd2, 32'h70, 3'b011);
        go(1, 1, 2'd1, 32'h71, 3'b011);
        go(1, 1, 2'd1, 32'h71, 3'b111);
        go(0, 0, 2'd0, 32'h0, 3'b111);
        go(0, 0, 2'd0, 32'h0, 3'b111);

        if (sb.size() != 0) check("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
